id_issue: RTL and testbench

Decode-and-issue pipeline stage for the RV32 integer pipeline. It accepts fetched instructions over a valid/ready handshake, decodes them, and reads the register file combinationally. It registers the operands and control fields that the execute stage consumes: `A`, `B`, `alu_op`, `B_wire`, `branch`. It also detects load-use hazards, inserts bubbles for them, and flushes on a taken branch.

---
 rtl/id_issue.sv | 265 ++++++++++++++++++++++++++
 tb/tb_id_issue.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_issue.sv
// id_issue: RV32 decode-and-issue stage. Decodes the fetched instruction,
// reads the register file combinationally, detects load-use hazards and
// holds the execute-stage operands in an issue register.
module id_issue #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            if_valid,
    input  logic [XLEN-1:0] if_instr,
    input  logic [XLEN-1:0] if_pc,
    output logic            if_ready,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    input  logic            ex_ready,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_A,
    output logic [XLEN-1:0] ex_B,
    output logic [2:0]      ex_alu_op,
    output logic [1:0]      ex_B_wire,
    output logic            ex_branch,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic [XLEN-1:0] ex_store_data,
    output logic [4:0]      ex_rd,
    output logic            ex_we,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_imm,
    output logic            ex_illegal
);

    localparam int unsigned RW   = 5;
    localparam int unsigned AOPW = 3;
    localparam int unsigned BWW  = 2;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LD  = 7'b0000011;
    localparam logic [6:0] OP_ST  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;

    localparam logic [AOPW-1:0] ALU_ADD = 3'd0;
    localparam logic [AOPW-1:0] ALU_SUB = 3'd1;
    localparam logic [AOPW-1:0] ALU_AND = 3'd2;
    localparam logic [AOPW-1:0] ALU_OR  = 3'd3;
    localparam logic [AOPW-1:0] ALU_XOR = 3'd4;
    localparam logic [AOPW-1:0] ALU_SLL = 3'd5;
    localparam logic [AOPW-1:0] ALU_SRL = 3'd6;
    localparam logic [AOPW-1:0] ALU_SRA = 3'd7;

    // instruction fields
    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    logic [RW-1:0]   w_rd;
    logic [XLEN-1:0] w_imm_i;
    logic [XLEN-1:0] w_imm_s;
    logic [XLEN-1:0] w_imm_b;

    // decoded payload
    logic            w_legal;
    logic [AOPW-1:0] w_alu_op;
    logic [XLEN-1:0] w_B;
    logic [XLEN-1:0] w_imm;
    logic [BWW-1:0]  w_B_wire;
    logic            w_branch;
    logic            w_mem_read;
    logic            w_mem_write;
    logic            w_writes_rd;
    logic            w_uses_rs2;
    logic            w_we;

    // handshake / hazard
    logic            w_hazard;
    logic            w_accept;
    logic            w_load;
    logic            w_kill;

    // issue register
    logic            r_valid;
    logic [XLEN-1:0] r_A;
    logic [XLEN-1:0] r_B;
    logic [AOPW-1:0] r_alu_op;
    logic [BWW-1:0]  r_B_wire;
    logic            r_branch;
    logic            r_mem_read;
    logic            r_mem_write;
    logic [XLEN-1:0] r_store_data;
    logic [RW-1:0]   r_rd;
    logic            r_we;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;
    logic            r_illegal;

    assign w_opcode = if_instr[6:0];
    assign w_rd     = if_instr[11:7];
    assign w_funct3 = if_instr[14:12];
    assign w_funct7 = if_instr[31:25];
    assign rs1_addr = if_instr[19:15];
    assign rs2_addr = if_instr[24:20];

    assign w_imm_i = {{(XLEN-12){if_instr[31]}}, if_instr[31:20]};
    assign w_imm_s = {{(XLEN-12){if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
    assign w_imm_b = {{(XLEN-13){if_instr[31]}}, if_instr[31], if_instr[7],
                      if_instr[30:25], if_instr[11:8], 1'b0};

    // Decode the incoming instruction; anything unmatched stays illegal.
    always_comb begin
        w_legal     = 1'b0;
        w_alu_op    = ALU_ADD;
        w_B         = rs2_data;
        w_imm       = '0;
        w_B_wire    = '0;
        w_branch    = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_writes_rd = 1'b0;
        w_uses_rs2  = 1'b0;
        case (w_opcode)
            OP_R: begin
                w_uses_rs2  = 1'b1;
                w_writes_rd = 1'b1;
                w_legal     = 1'b1;
                case ({w_funct7, w_funct3})
                    10'h000: w_alu_op = ALU_ADD;
                    10'h100: w_alu_op = ALU_SUB;
                    10'h007: w_alu_op = ALU_AND;
                    10'h006: w_alu_op = ALU_OR;
                    10'h004: w_alu_op = ALU_XOR;
                    10'h001: w_alu_op = ALU_SLL;
                    10'h005: w_alu_op = ALU_SRL;
                    10'h105: w_alu_op = ALU_SRA;
                    default: w_legal  = 1'b0;
                endcase
            end
            OP_I: begin
                w_writes_rd = 1'b1;
                w_B         = w_imm_i;
                w_imm       = w_imm_i;
                case (w_funct3)
                    3'd0: begin w_alu_op = ALU_ADD; w_legal = 1'b1; end
                    3'd7: begin w_alu_op = ALU_AND; w_legal = 1'b1; end
                    3'd6: begin w_alu_op = ALU_OR;  w_legal = 1'b1; end
                    3'd4: begin w_alu_op = ALU_XOR; w_legal = 1'b1; end
                    3'd1: begin
                        w_alu_op = ALU_SLL;
                        w_B      = XLEN'(if_instr[24:20]);
                        w_legal  = (w_funct7 == 7'h00);
                    end
                    3'd5: begin
                        w_alu_op = (w_funct7 == 7'h20) ? ALU_SRA : ALU_SRL;
                        w_B      = XLEN'(if_instr[24:20]);
                        w_legal  = (w_funct7 == 7'h00) || (w_funct7 == 7'h20);
                    end
                    default: w_legal = 1'b0;
                endcase
            end
            OP_LD: begin
                w_writes_rd = 1'b1;
                w_mem_read  = 1'b1;
                w_B         = w_imm_i;
                w_imm       = w_imm_i;
                w_legal     = (w_funct3 == 3'd2);
            end
            OP_ST: begin
                w_uses_rs2  = 1'b1;
                w_mem_write = 1'b1;
                w_B         = w_imm_s;
                w_imm       = w_imm_s;
                w_legal     = (w_funct3 == 3'd2);
            end
            OP_BR: begin
                w_uses_rs2 = 1'b1;
                w_branch   = 1'b1;
                w_alu_op   = ALU_SUB;
                w_imm      = w_imm_b;
                w_legal    = 1'b1;
                case (w_funct3)
                    3'd0:    w_B_wire = 2'b00;
                    3'd1:    w_B_wire = 2'b01;
                    3'd4:    w_B_wire = 2'b10;
                    3'd5:    w_B_wire = 2'b11;
                    default: w_legal  = 1'b0;
                endcase
            end
            default: w_legal = 1'b0;
        endcase
    end

    assign w_we = w_writes_rd && w_legal && (w_rd != '0);

    // Load in the issue register whose result the incoming instruction needs.
    assign w_hazard = r_valid && r_mem_read && (r_rd != '0) &&
                      ((r_rd == rs1_addr) || (w_uses_rs2 && (r_rd == rs2_addr)));

    assign if_ready = flush || ((!r_valid || ex_ready) && !w_hazard);
    assign w_accept = if_valid && if_ready;
    // Load and kill are mutually exclusive: a hazard blocks acceptance unless
    // flushing, and an idle input cannot be accepted.
    assign w_load   = w_accept && !flush;
    assign w_kill   = flush || (w_hazard && ex_ready) || (ex_ready && !if_valid);

    // Issue register: kill/bubble, load a new instruction, or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_A          <= '0;
            r_B          <= '0;
            r_alu_op     <= '0;
            r_B_wire     <= '0;
            r_branch     <= 1'b0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
            r_store_data <= '0;
            r_rd         <= '0;
            r_we         <= 1'b0;
            r_pc         <= '0;
            r_imm        <= '0;
            r_illegal    <= 1'b0;
        end else begin
            r_illegal <= 1'b0;
            if (w_kill) begin
                r_valid     <= 1'b0;
                r_branch    <= 1'b0;
                r_mem_read  <= 1'b0;
                r_mem_write <= 1'b0;
                r_we        <= 1'b0;
            end else if (w_load) begin
                r_valid      <= w_legal;
                r_illegal    <= !w_legal;
                r_A          <= rs1_data;
                r_B          <= w_B;
                r_alu_op     <= w_alu_op;
                r_B_wire     <= w_B_wire;
                r_branch     <= w_branch && w_legal;
                r_mem_read   <= w_mem_read && w_legal;
                r_mem_write  <= w_mem_write && w_legal;
                r_store_data <= rs2_data;
                r_rd         <= w_rd;
                r_we         <= w_we;
                r_pc         <= if_pc;
                r_imm        <= w_imm;
            end
        end
    end

    assign ex_valid      = r_valid;
    assign ex_A          = r_A;
    assign ex_B          = r_B;
    assign ex_alu_op     = r_alu_op;
    assign ex_B_wire     = r_B_wire;
    assign ex_branch     = r_branch;
    assign ex_mem_read   = r_mem_read;
    assign ex_mem_write  = r_mem_write;
    assign ex_store_data = r_store_data;
    assign ex_rd         = r_rd;
    assign ex_we         = r_we;
    assign ex_pc         = r_pc;
    assign ex_imm        = r_imm;
    assign ex_illegal    = r_illegal;

endmodule

// File: tb/tb_id_issue.sv
// tb_id_issue: scoreboard bench for id_issue. A mask/match opcode table
// model predicts the issue register each cycle; a monitor compares.
module tb_id_issue;

    localparam int K_R = 0, K_I = 1, K_SH = 2, K_LW = 3, K_SW = 4, K_BR = 5, K_ILL = 6;
    localparam int NT = 21;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr, if_pc;
    logic        if_ready;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [31:0] rs1_data, rs2_data;
    logic        flush, ex_ready;
    logic        ex_valid;
    logic [31:0] ex_A, ex_B;
    logic [2:0]  ex_alu_op;
    logic [1:0]  ex_B_wire;
    logic        ex_branch, ex_mem_read, ex_mem_write;
    logic [31:0] ex_store_data;
    logic [4:0]  ex_rd;
    logic        ex_we;
    logic [31:0] ex_pc, ex_imm;
    logic        ex_illegal;

    id_issue #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc), .if_ready(if_ready),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
        .ex_A(ex_A), .ex_B(ex_B), .ex_alu_op(ex_alu_op), .ex_B_wire(ex_B_wire),
        .ex_branch(ex_branch), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_we(ex_we),
        .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    // Instruction table: mask, match, kind, alu op, branch type.
    logic [31:0] t_mask [NT] = '{
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F,
        32'hFE00707F, 32'hFE00707F, 32'hFE00707F,
        32'h0000707F, 32'h0000707F,
        32'h0000707F, 32'h0000707F, 32'h0000707F, 32'h0000707F};
    logic [31:0] t_match [NT] = '{
        32'h00000033, 32'h40000033, 32'h00007033, 32'h00006033, 32'h00004033,
        32'h00001033, 32'h00005033, 32'h40005033,
        32'h00000013, 32'h00007013, 32'h00006013, 32'h00004013,
        32'h00001013, 32'h00005013, 32'h40005013,
        32'h00002003, 32'h00002023,
        32'h00000063, 32'h00001063, 32'h00004063, 32'h00005063};
    int t_kind [NT] = '{K_R, K_R, K_R, K_R, K_R, K_R, K_R, K_R,
                        K_I, K_I, K_I, K_I, K_SH, K_SH, K_SH,
                        K_LW, K_SW, K_BR, K_BR, K_BR, K_BR};
    logic [2:0] t_alu [NT] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                               3'd0, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                               3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1};
    logic [1:0] t_bw [NT] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                              2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0,
                              2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3};

    typedef struct {
        logic        valid, illegal, we, mr, mw, br;
        logic [2:0]  alu;
        logic [1:0]  bw;
        logic [31:0] a, b, imm, pc, sd;
        logic [4:0]  rd;
        int          kind;
    } exp_t;

    exp_t m;
    exp_t q[$];
    int   n_chk = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t decode(input logic [31:0] ins, input logic [31:0] pc,
                                    input logic [31:0] d1, input logic [31:0] d2);
        exp_t e;
        int   idx = -1;
        logic [31:0] ii, is, ib;
        for (int i = NT - 1; i >= 0; i--)
            if ((ins & t_mask[i]) == t_match[i]) idx = i;
        ii = {{20{ins[31]}}, ins[31:20]};
        is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        e = '{default: '0};
        e.pc = pc; e.a = d1; e.sd = d2; e.rd = ins[11:7];
        if (idx < 0) begin
            e.kind = K_ILL; e.illegal = 1'b1;
            return e;
        end
        e.kind = t_kind[idx]; e.alu = t_alu[idx]; e.bw = t_bw[idx];
        e.valid = 1'b1;
        case (e.kind)
            K_R:  e.b = d2;
            K_I:  begin e.b = ii; e.imm = ii; end
            K_SH: e.b = {27'd0, ins[24:20]};
            K_LW: begin e.b = ii; e.imm = ii; e.mr = 1'b1; end
            K_SW: begin e.b = is; e.imm = is; e.mw = 1'b1; end
            default: begin e.b = d2; e.imm = ib; e.br = 1'b1; end
        endcase
        e.we = (e.kind <= K_LW) && (e.rd != 5'd0);
        return e;
    endfunction

    function automatic exp_t bubble(input exp_t e);
        exp_t r = e;
        r.valid = 1'b0; r.we = 1'b0; r.mr = 1'b0; r.mw = 1'b0; r.br = 1'b0;
        return r;
    endfunction

    // Drive one cycle, check the combinational outputs, predict the next state.
    task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                        input logic fl, input logic er,
                        input logic [31:0] d1, input logic [31:0] d2);
        exp_t nx;
        logic hz, rdy, u2;
        logic [4:0] a1, a2;
        @(negedge clk);
        if_valid = v; if_instr = ins; if_pc = pc; flush = fl; ex_ready = er;
        rs1_data = d1; rs2_data = d2;
        #1;
        a1 = ins[19:15]; a2 = ins[24:20];
        u2 = (ins[6:0] == 7'h33) || (ins[6:0] == 7'h23) || (ins[6:0] == 7'h63);
        hz = m.valid && m.mr && (m.rd != 5'd0) && ((m.rd == a1) || (u2 && (m.rd == a2)));
        rdy = fl || ((!m.valid || er) && !hz);
        chk("if_ready", 32'(if_ready), 32'(rdy));
        chk("rs_addr", 32'({rs1_addr, rs2_addr}), 32'({a1, a2}));
        nx = m;
        nx.illegal = 1'b0;
        if (fl || (hz && er)) nx = bubble(nx);
        else if (v && rdy)    nx = decode(ins, pc, d1, d2);
        else if (er && !v)    nx = bubble(nx);
        m = nx;
        q.push_back(nx);
        @(posedge clk);
    endtask

    task automatic check_cleared(input string nm);
        chk(nm, 32'(|{ex_valid, ex_A, ex_B, ex_alu_op, ex_B_wire, ex_branch, ex_mem_read,
                      ex_mem_write, ex_store_data, ex_rd, ex_we, ex_pc, ex_imm, ex_illegal}), 32'd0);
        chk({nm, "_if_ready"}, 32'(if_ready), 32'd1);
    endtask

    // Monitor: compare the issue register against the scoreboard every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("ex_valid", 32'(ex_valid), 32'(e.valid));
                chk("ex_illegal", 32'(ex_illegal), 32'(e.illegal));
                chk("ex_flags", 32'({ex_we, ex_mem_read, ex_mem_write, ex_branch}),
                    32'({e.we, e.mr, e.mw, e.br}));
                if (e.valid) begin
                    chk("ex_alu_op", 32'(ex_alu_op), 32'(e.alu));
                    chk("ex_A", ex_A, e.a);
                    chk("ex_B", ex_B, e.b);
                    chk("ex_pc", ex_pc, e.pc);
                    if (e.kind <= K_LW) chk("ex_rd", 32'(ex_rd), 32'(e.rd));
                    if (e.kind == K_I || e.kind >= K_LW) chk("ex_imm", ex_imm, e.imm);
                    if (e.kind == K_SW) chk("ex_store_data", ex_store_data, e.sd);
                    if (e.kind == K_BR) chk("ex_B_wire", 32'(ex_B_wire), 32'(e.bw));
                end
            end
        end
    end

    function automatic logic [31:0] gen_instr();
        logic [31:0] w;
        int idx;
        if ($urandom_range(0, 9) == 0) return $urandom;
        idx = $urandom_range(0, NT - 1);
        w = t_match[idx] | ($urandom & ~t_mask[idx]);
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        w[11:7]  = 5'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        m = '{default: '0};
        rst = 1'b1;
        if_valid = 1'b0; if_instr = '0; if_pc = '0; flush = 1'b0; ex_ready = 1'b0;
        rs1_data = '0; rs2_data = '0;
        repeat (2) @(negedge clk);
        #1;
        check_cleared("reset");
        @(negedge clk);
        rst = 1'b0;

        // back-to-back add / sub, then immediate
        step(1, 32'h002081B3, 32'h0, 0, 1, 32'd5, 32'd3);
        step(1, 32'h402081B3, 32'h4, 0, 1, 32'd5, 32'd3);
        step(1, 32'hFFF00293, 32'h8, 0, 1, 32'd9, 32'd9);
        // load-use: one bubble, then the add issues
        step(1, 32'h0040A303, 32'hC, 0, 1, 32'd100, 32'd0);
        step(1, 32'h000303B3, 32'h10, 0, 1, 32'd7, 32'd0);
        step(1, 32'h000303B3, 32'h10, 0, 1, 32'd7, 32'd0);
        // branch, then three stall cycles, then flush with a new instruction
        step(1, 32'h0020C463, 32'h100, 0, 1, 32'd1, 32'd2);
        for (int i = 0; i < 3; i++) step(1, 32'h002081B3, 32'h104, 0, 0, 32'd1, 32'd2);
        step(1, 32'h402081B3, 32'h104, 1, 0, 32'd1, 32'd2);
        step(0, 32'h0, 32'h0, 0, 1, 32'd0, 32'd0);
        // store, illegal, then idle
        step(1, 32'h0020A223, 32'h200, 0, 1, 32'd16, 32'hCAFE);
        step(1, 32'h0000007F, 32'h204, 0, 1, 32'd0, 32'd0);
        step(0, 32'h0, 32'h0, 0, 1, 32'd0, 32'd0);
        step(0, 32'h0, 32'h0, 0, 1, 32'd0, 32'd0);
        // reset asserted mid-stall
        step(1, 32'h002081B3, 32'h300, 0, 1, 32'd5, 32'd3);
        step(1, 32'h402081B3, 32'h304, 0, 0, 32'd5, 32'd3);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        flush = 1'b0;
        #0;
        check_cleared("mid_stall_reset");
        m = '{default: '0};
        @(negedge clk);
        rst = 1'b0;

        // randomized traffic
        for (int i = 0; i < 500; i++)
            step(32'($urandom_range(0, 99)) < 80, gen_instr(), $urandom & 32'hFFFFFFFC,
                 32'($urandom_range(0, 99)) < 8, 32'($urandom_range(0, 99)) < 70,
                 $urandom, $urandom);

        repeat (2) @(posedge clk);
        #2;
        chk("scoreboard_drained", 32'(q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
